valu_wb_round: RTL
==================

# valu_wb_round

Write-back stage that sits on the result side of the vector add/min/max pipeline. It accepts that pipeline's non-stallable output beat stream (data, address, byte enables, mask flag, fixed-point rounding bits). For fixed-point averaging beats it applies per-element `vxrm` rounding, then buffers beats in a FIFO. Beats are presented to the vector register file write port through a valid/ready handshake. Back-pressure is reported to the issue logic through an almost-full flag, because the upstream ALU cannot stall.

## Interface
Parameters:
- `DATA_WIDTH`, 64: beat data width; must be 64 (8 byte lanes).
- `BE_WIDTH`, `DATA_WIDTH/8`: byte-enable width.
- `ADDR_WIDTH`, 32: write address width.
- `FIFO_DEPTH`, 8: buffer entries; power of two, ≥ 2.
- `AFULL_SLACK`, 6: `out_afull` asserts when free entries ≤ `AFULL_SLACK`.

Ports:
- `clk`  in  1  clock; one clock domain. All logic is on `posedge clk`.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  result beat valid. Cannot be stalled.
- `in_vec`  in  `DATA_WIDTH`  result data.
- `in_addr`  in  `ADDR_WIDTH`  destination address.
- `in_be`  in  `BE_WIDTH`  byte enables.
- `in_mask`  in  1  beat is packed mask bits. No rounding is ever applied.
- `in_fxp`  in  1  beat is an averaging result that needs rounding.
- `in_vd`  in  `BE_WIDTH`  bit at element base-byte index = v[d] (result LSB).
- `in_vd1`  in  `BE_WIDTH`  bit at element base-byte index = v[d-1] (shifted-out bit).
- `in_sew`  in  2  element width: 0=8, 1=16, 2=32, 3=64 bits. Stable for an instruction.
- `in_vxrm`  in  2  rounding mode: 0=rnu, 1=rne, 2=rdn, 3=rod.
- `wr_ready`  in  1  register file accepts the beat.
- `wr_valid`  out  1  write beat valid.
- `wr_data`  out  `DATA_WIDTH`  write data.
- `wr_addr`  out  `ADDR_WIDTH`  write address.
- `wr_be`  out  `BE_WIDTH`  write byte enables.
- `out_afull`  out  1  issue throttle.
- `out_overflow`  out  1  sticky; set when a beat was dropped.

## Operation
- Stage R (registered): capture the input beat when `in_valid`. If `in_fxp & ~in_mask`, round each element; otherwise pass data through unchanged. `addr`, `be` and `mask` pass through.
- Rounding increment per element, with v0 = `in_vd1[base]` and v1 = `in_vd[base]`, where base = element index << `in_sew`:
  - rnu: r = v0
  - rne: r = v0 & v1
  - rdn: r = 0
  - rod: r = v0 & ~v1
- The element value plus r wraps modulo 2^SEW. There is no carry between elements.
- FIFO:
  - Stage R output is pushed the cycle after capture.
  - Pop occurs when `wr_valid & wr_ready`.
  - The head is shown first-word-fall-through on the `wr_*` registers.
- Full with a push and no pop: the beat is dropped and `out_overflow` is set. It stays set until `rst`.
- Full with a simultaneous push and pop: both happen, the count is unchanged, and nothing is dropped.
- Empty: `wr_valid`=0. While `wr_valid`=1, the `wr_*` outputs hold stable until accepted.
- `out_afull` is a registered function of the occupancy after each cycle's push/pop.

## Timing
- Reset values: `wr_valid`=0, `wr_data`=0, `wr_addr`=0, `wr_be`=0, `out_afull`=0, `out_overflow`=0. The FIFO is emptied and stage R is invalidated.
- A reset mid-operation discards all buffered beats. The next cycle is idle.
- Latency from an input beat (cycle N) with the FIFO empty: `wr_valid`=1 at cycle N+2.
- Throughput is one beat per cycle when `wr_ready`=1 continuously.
- Ordering is strictly in-order.
- `wr_ready` may toggle arbitrarily. Outputs do not depend combinationally on `wr_ready`.

## Configuration
- `VALU_WB_FXP_EN`:
  - Defined: the rounding logic is present as described.
  - Undefined: `in_fxp`, `in_vd`, `in_vd1` and `in_vxrm` are ignored, data always passes unchanged, and latency is unchanged.

## Structure
- Shared package `valu_pkg`:
  - SEW encoding constants.
  - vxrm encoding enum (`VXRM_RNU`, `VXRM_RNE`, `VXRM_RDN`, `VXRM_ROD`).
  - Beat struct: data, addr, be, mask.
- One sub-module, `vxrm_round_lanes`: combinational per-SEW element rounding, instantiated only under `VALU_WB_FXP_EN`.
- The FIFO is inline: pointers with an extra wrap bit, plus an occupancy counter.

## Test plan
1. Rounding modes at SEW=8, `in_fxp`=1, byte0 = 0x05, `in_vd`[0]=1, `in_vd1`[0]=1:
   - rnu → 0x06, rne → 0x06, rdn → 0x05, rod → 0x05.
   - Repeat with byte0 = 0x04, vd=0, vd1=1: rnu → 0x05, rne → 0x04, rod → 0x05.
2. Wrap at SEW=32, rnu, lower word 0xFFFFFFFF, vd1[0]=1, upper word 0x00000001, vd1[4]=0:
   - → `wr_data` = 0x00000001_00000000. The upper word is unaffected.
3. Mask beat, `in_mask`=1, `in_fxp`=1, data 0xA5 → written unchanged, with `wr_be` and `wr_addr` passed through.
4. Back-pressure: hold `wr_ready`=0 and stream 8 beats.
   - `out_afull` rises when free entries ≤ 6.
   - A 9th beat sets `out_overflow`.
   - Release `wr_ready`: beats 1–8 are written in order and the 9th is absent.
5. Full FIFO with push and pop in the same cycle → no drop, `out_overflow` stays 0, count remains 8.
6. Assert `rst` with 3 beats buffered → next cycle `wr_valid`=0, `out_afull`=0, `out_overflow`=0. A new beat appears 2 cycles after injection.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared types for the vector ALU result path: SEW codes, vxrm modes, beat record
// and the per-element rounding increment.
package valu_pkg;

    localparam int VALU_DATA_W = 64;
    localparam int VALU_BE_W   = VALU_DATA_W / 8;
    localparam int VALU_ADDR_W = 32;

    localparam logic [1:0] SEW_E8  = 2'd0;
    localparam logic [1:0] SEW_E16 = 2'd1;
    localparam logic [1:0] SEW_E32 = 2'd2;
    localparam logic [1:0] SEW_E64 = 2'd3;

    typedef enum logic [1:0] {
        VXRM_RNU = 2'd0,
        VXRM_RNE = 2'd1,
        VXRM_RDN = 2'd2,
        VXRM_ROD = 2'd3
    } vxrm_e;

    typedef struct packed {
        logic [VALU_DATA_W-1:0] data;
        logic [VALU_ADDR_W-1:0] addr;
        logic [VALU_BE_W-1:0]   be;
        logic                   mask;
    } beat_t;

    // v0 is the shifted-out bit, v1 the result LSB
    function automatic logic round_inc(input vxrm_e mode, input logic v0, input logic v1);
        logic r;
        case (mode)
            VXRM_RNU: r = v0;
            VXRM_RNE: r = v0 & v1;
            VXRM_RDN: r = 1'b0;
            VXRM_ROD: r = v0 & ~v1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vxrm_round_lanes.sv
// Combinational per-element fixed-point rounding of one 64-bit beat; each element
// wraps on its own, no carry crosses an element boundary.
module vxrm_round_lanes
    import valu_pkg::*;
(
    input  logic [VALU_DATA_W-1:0] data_i,
    input  logic [VALU_BE_W-1:0]   vd_i,
    input  logic [VALU_BE_W-1:0]   vd1_i,
    input  logic [1:0]             sew_i,
    input  vxrm_e                  vxrm_i,
    output logic [VALU_DATA_W-1:0] data_o
);

    // Rounding bits sit at each element's base byte index
    always_comb begin
        data_o = data_i;
        case (sew_i)
            SEW_E8: begin
                for (int e = 0; e < 8; e++) begin
                    data_o[e*8 +: 8] = data_i[e*8 +: 8]
                        + {7'd0, round_inc(vxrm_i, vd1_i[e], vd_i[e])};
                end
            end
            SEW_E16: begin
                for (int e = 0; e < 4; e++) begin
                    data_o[e*16 +: 16] = data_i[e*16 +: 16]
                        + {15'd0, round_inc(vxrm_i, vd1_i[e*2], vd_i[e*2])};
                end
            end
            SEW_E32: begin
                for (int e = 0; e < 2; e++) begin
                    data_o[e*32 +: 32] = data_i[e*32 +: 32]
                        + {31'd0, round_inc(vxrm_i, vd1_i[e*4], vd_i[e*4])};
                end
            end
            SEW_E64: begin
                data_o = data_i + {63'd0, round_inc(vxrm_i, vd1_i[0], vd_i[0])};
            end
            default: begin
                data_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/valu_wb_round.sv
// Vector ALU write-back: optional vxrm rounding stage, then a FWFT FIFO toward the
// register file. Rounding is built only when VALU_WB_FXP_EN is defined.
module valu_wb_round
    import valu_pkg::*;
#(
    parameter int DATA_WIDTH  = VALU_DATA_W,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH  = VALU_ADDR_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int AFULL_SLACK = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [BE_WIDTH-1:0]   in_be,
    input  logic                  in_mask,
    input  logic                  in_fxp,
    input  logic [BE_WIDTH-1:0]   in_vd,
    input  logic [BE_WIDTH-1:0]   in_vd1,
    input  logic [1:0]            in_sew,
    input  logic [1:0]            in_vxrm,
    input  logic                  wr_ready,
    output logic                  wr_valid,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BE_WIDTH-1:0]   wr_be,
    output logic                  out_afull,
    output logic                  out_overflow
);

    localparam int             PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C     = (PTR_W+1)'(FIFO_DEPTH);
    localparam int             AFULL_LVL_I = (FIFO_DEPTH > AFULL_SLACK) ? (FIFO_DEPTH - AFULL_SLACK) : 0;
    localparam logic [PTR_W:0] AFULL_LVL   = (PTR_W+1)'(AFULL_LVL_I);
    localparam logic [PTR_W:0] ZERO_C      = {(PTR_W+1){1'b0}};

    beat_t                 in_beat_s;
    beat_t                 r_beat_q;
    logic                  r_valid_q;
    beat_t                 mem_q [FIFO_DEPTH];
    beat_t                 head_s;
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d, count_pop_s;
    logic                  push_s, pop_s, full_s, drop_s, wr_en_s, afull_d;
    logic                  wr_valid_q, afull_q, overflow_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [BE_WIDTH-1:0]   wr_be_q;
    logic                  mask_unused;

`ifdef VALU_WB_FXP_EN
    logic [DATA_WIDTH-1:0] rnd_data_s;

    vxrm_round_lanes u_round (
        .data_i (in_vec),
        .vd_i   (in_vd),
        .vd1_i  (in_vd1),
        .sew_i  (in_sew),
        .vxrm_i (vxrm_e'(in_vxrm)),
        .data_o (rnd_data_s)
    );
`else
    logic fxp_unused;
    assign fxp_unused = ^{in_fxp, in_vd, in_vd1, in_sew, in_vxrm};
`endif

    // Mask beats carry packed mask bits and are never rounded
    always_comb begin
        in_beat_s.addr = in_addr;
        in_beat_s.be   = in_be;
        in_beat_s.mask = in_mask;
`ifdef VALU_WB_FXP_EN
        if (in_fxp & ~in_mask) begin
            in_beat_s.data = rnd_data_s;
        end else begin
            in_beat_s.data = in_vec;
        end
`else
        in_beat_s.data = in_vec;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_beat_q  <= '0;
        end else begin
            r_valid_q <= in_valid;
            if (in_valid) begin
                r_beat_q <= in_beat_s;
            end
        end
    end

    // When the FIFO drains to zero this cycle, the incoming push becomes the new head
    always_comb begin
        push_s      = r_valid_q;
        pop_s       = wr_valid_q & wr_ready;
        full_s      = (count_q == DEPTH_C);
        drop_s      = push_s & full_s & ~pop_s;
        wr_en_s     = push_s & ~drop_s;
        wr_ptr_d    = wr_ptr_q + {{PTR_W{1'b0}}, wr_en_s};
        rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, pop_s};
        count_pop_s = count_q - {{PTR_W{1'b0}}, pop_s};
        count_d     = count_pop_s + {{PTR_W{1'b0}}, wr_en_s};
        afull_d     = (count_d >= AFULL_LVL);
        if (count_pop_s == ZERO_C) begin
            head_s = r_beat_q;
        end else begin
            head_s = mem_q[rd_ptr_d[PTR_W-1:0]];
        end
    end

    assign mask_unused = head_s.mask;

    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= r_beat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= ZERO_C;
            rd_ptr_q   <= ZERO_C;
            count_q    <= ZERO_C;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            wr_be_q    <= '0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_q | drop_s;
            wr_valid_q <= (count_d != ZERO_C);
            if (count_d != ZERO_C) begin
                wr_data_q <= head_s.data;
                wr_addr_q <= head_s.addr;
                wr_be_q   <= head_s.be;
            end
        end
    end

    assign wr_valid     = wr_valid_q;
    assign wr_data      = wr_data_q;
    assign wr_addr      = wr_addr_q;
    assign wr_be        = wr_be_q;
    assign out_afull    = afull_q;
    assign out_overflow = overflow_q;

endmodule
